// File: rtl/usb_packet_buffer_controller.sv
// usb_packet_buffer_controller
//
// Owns a two-bank packet RAM (2 x 256 words). The USB receiver fills one bank
// while the CPU drains the other; banks cycle FREE -> FILLING -> READY -> FREE.
// The single RAM port is shared: a USB write always wins, and a CPU read is
// granted only when the port is idle and no read is outstanding.
//
// Ports:
//   clock48, reset                      48 MHz clock, async active-high reset
//   usb_start/usb_write/usb_end         receiver packet framing and word strobe
//   usb_write_index, usb_write_data     word position and value
//   usb_accept                          write bank is FREE (combinational)
//   cpu_read_request/index              level request for one word of the CPU bank
//   cpu_read_ready, cpu_read_data       one-cycle completion pulse and word
//   cpu_release                         CPU is done with the current packet
//   packet_interrupt, packet_length     packet waiting / its word count
//   dropped_count                       saturating count of dropped packets
//   ram_enable/write/address/write_data RAM port, address = {bank, index}
//   ram_read_data                       RAM read data, one cycle after enable
module usb_packet_buffer_controller #(
  parameter int WORD_INDEX_WIDTH = 8,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                        clock48,
  input  logic                        reset,
  input  logic                        usb_start,
  input  logic                        usb_write,
  input  logic [WORD_INDEX_WIDTH-1:0] usb_write_index,
  input  logic [DATA_WIDTH-1:0]       usb_write_data,
  input  logic                        usb_end,
  output logic                        usb_accept,
  input  logic                        cpu_read_request,
  input  logic [WORD_INDEX_WIDTH-1:0] cpu_read_index,
  output logic                        cpu_read_ready,
  output logic [DATA_WIDTH-1:0]       cpu_read_data,
  input  logic                        cpu_release,
  output logic                        packet_interrupt,
  output logic [WORD_INDEX_WIDTH:0]   packet_length,
  output logic [7:0]                  dropped_count,
  output logic                        ram_enable,
  output logic                        ram_write,
  output logic [WORD_INDEX_WIDTH:0]   ram_address,
  output logic [DATA_WIDTH-1:0]       ram_write_data,
  input  logic [DATA_WIDTH-1:0]       ram_read_data
);

  localparam int LEN_W = WORD_INDEX_WIDTH + 1;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2
  } bank_state_t;

  bank_state_t           bank_state  [2];
  logic [LEN_W-1:0]      bank_length [2];
  logic                  write_bank;
  logic                  read_bank;
  logic [7:0]            drop_count;
  logic                  irq;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;

  logic write_filling;
  logic write_free;
  logic write_access;
  logic read_bank_ready;
  logic read_grant;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Packet length is the highest index written plus one; 256 fits in LEN_W bits.
  function automatic logic [LEN_W-1:0] len_extend(input logic [LEN_W-1:0] cur,
                                                  input logic [WORD_INDEX_WIDTH-1:0] idx);
    logic [LEN_W-1:0] ext;
    ext = {1'b0, idx} + LEN_W'(1);
    return (ext > cur) ? ext : cur;
  endfunction

  assign write_filling   = (bank_state[write_bank] == BANK_FILLING);
  assign write_free      = (bank_state[write_bank] == BANK_FREE);
  assign write_access    = usb_write && write_filling;
  assign read_bank_ready = (bank_state[read_bank] == BANK_READY);
  // rd_vld_p1 blocks a second grant during the completion cycle, while the
  // CPU is still holding its request before it sees cpu_read_ready.
  assign read_grant      = cpu_read_request && !usb_write && !rd_vld_p1 && read_bank_ready;

  assign usb_accept       = write_free;
  assign packet_length    = bank_length[read_bank];
  assign packet_interrupt = irq;
  assign dropped_count    = drop_count;
  assign cpu_read_ready   = rd_vld_p1;
  // Data is live from the RAM on the completion cycle and held afterwards.
  assign cpu_read_data    = rd_vld_p1 ? ram_read_data : rd_data_p1;

  // ---- p0: RAM port request (combinational, forced idle during reset) ----
  always_comb begin
    ram_enable     = 1'b0;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_write_data = '0;
    if (!reset) begin
      if (write_access) begin
        ram_enable     = 1'b1;
        ram_write      = 1'b1;
        ram_address    = {write_bank, usb_write_index};
        ram_write_data = usb_write_data;
      end else if (read_grant) begin
        ram_enable  = 1'b1;
        ram_address = {read_bank, cpu_read_index};
      end
    end
  end

  // ---- p1: bank sequencing, read completion, interrupt ----
  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      bank_state[0]  <= BANK_FREE;
      bank_state[1]  <= BANK_FREE;
      bank_length[0] <= '0;
      bank_length[1] <= '0;
      write_bank     <= 1'b0;
      read_bank      <= 1'b0;
      drop_count     <= 8'd0;
      irq            <= 1'b0;
      rd_vld_p1      <= 1'b0;
      rd_data_p1     <= '0;
    end else begin
      irq       <= read_bank_ready;
      rd_vld_p1 <= read_grant;
      if (rd_vld_p1) begin
        rd_data_p1 <= ram_read_data;
      end

      // Start is judged on the pre-release state, so a start that coincides
      // with the release of the write bank is still a drop.
      if (usb_start) begin
        if (write_free) begin
          bank_state[write_bank]  <= BANK_FILLING;
          bank_length[write_bank] <= '0;
        end else if (bank_state[write_bank] == BANK_READY) begin
          drop_count <= sat_inc8(drop_count);
        end
      end

      if (write_access) begin
        bank_length[write_bank] <= len_extend(bank_length[write_bank], usb_write_index);
      end

      if (usb_end && write_filling) begin
        bank_state[write_bank] <= BANK_READY;
        write_bank             <= ~write_bank;
      end

      // A READY read bank can never be the FILLING write bank, so this and
      // the end-of-packet update never touch the same bank in one cycle.
      if (cpu_release && read_bank_ready) begin
        bank_state[read_bank] <= BANK_FREE;
        read_bank             <= ~read_bank;
      end
    end
  end

endmodule

// File: tb/tb_usb_packet_buffer_controller.sv
// Directed testbench for usb_packet_buffer_controller with a behavioural
// one-cycle-latency RAM attached to the RAM port.
module tb_usb_packet_buffer_controller;

  logic        clock48 = 1'b0;
  logic        reset;
  logic        usb_start;
  logic        usb_write;
  logic [7:0]  usb_write_index;
  logic [31:0] usb_write_data;
  logic        usb_end;
  logic        usb_accept;
  logic        cpu_read_request;
  logic [7:0]  cpu_read_index;
  logic        cpu_read_ready;
  logic [31:0] cpu_read_data;
  logic        cpu_release;
  logic        packet_interrupt;
  logic [8:0]  packet_length;
  logic [7:0]  dropped_count;
  logic        ram_enable;
  logic        ram_write;
  logic [8:0]  ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data = 32'd0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [512];

  always #5 clock48 = ~clock48;

  always @(posedge clock48) begin
    if (ram_enable) begin
      if (ram_write) mem[ram_address] <= ram_write_data;
      else           ram_read_data    <= mem[ram_address];
    end
  end

  usb_packet_buffer_controller #(.WORD_INDEX_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clock48          (clock48),
    .reset            (reset),
    .usb_start        (usb_start),
    .usb_write        (usb_write),
    .usb_write_index  (usb_write_index),
    .usb_write_data   (usb_write_data),
    .usb_end          (usb_end),
    .usb_accept       (usb_accept),
    .cpu_read_request (cpu_read_request),
    .cpu_read_index   (cpu_read_index),
    .cpu_read_ready   (cpu_read_ready),
    .cpu_read_data    (cpu_read_data),
    .cpu_release      (cpu_release),
    .packet_interrupt (packet_interrupt),
    .packet_length    (packet_length),
    .dropped_count    (dropped_count),
    .ram_enable       (ram_enable),
    .ram_write        (ram_write),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock48);
  endtask

  task automatic send_start();
    usb_start = 1'b1;
    cyc();
    usb_start = 1'b0;
  endtask

  task automatic send_end();
    usb_end = 1'b1;
    cyc();
    usb_end = 1'b0;
  endtask

  task automatic release_pkt();
    cpu_release = 1'b1;
    cyc();
    cpu_release = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] idx, input logic [31:0] data,
                            input logic expect_access, input logic [8:0] addr);
    usb_write       = 1'b1;
    usb_write_index = idx;
    usb_write_data  = data;
    #1;
    if (expect_access) begin
      chk("wr_enable", 64'(ram_enable), 64'(1));
      chk("wr_write",  64'(ram_write),  64'(1));
      chk("wr_addr",   64'(ram_address), 64'(addr));
      chk("wr_data",   64'(ram_write_data), 64'(data));
    end else begin
      chk("wr_blocked", 64'(ram_enable), 64'(0));
    end
    cyc();
    usb_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    usb_start = 1'b0; usb_write = 1'b0; usb_write_index = 8'd0; usb_write_data = 32'd0;
    usb_end = 1'b0; cpu_read_request = 1'b0; cpu_read_index = 8'd0; cpu_release = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst_accept", 64'(usb_accept), 64'(1));
    chk("rst_irq",    64'(packet_interrupt), 64'(0));
    chk("rst_len",    64'(packet_length), 64'(0));
    chk("rst_drop",   64'(dropped_count), 64'(0));
    chk("rst_ready",  64'(cpu_read_ready), 64'(0));
    chk("rst_rdata",  64'(cpu_read_data), 64'(0));
    chk("rst_ram_en", 64'(ram_enable), 64'(0));
    reset = 1'b0;
    cyc();

    // Basic packet into bank 0, read word 2, release
    send_start();
    chk("t1_accept_filling", 64'(usb_accept), 64'(0));
    for (int i = 0; i < 4; i++) send_write(8'(i), 32'(32'hA0 + i), 1'b1, 9'(i));
    send_end();
    chk("t1_irq_lag", 64'(packet_interrupt), 64'(0));
    cyc();
    chk("t1_irq", 64'(packet_interrupt), 64'(1));
    chk("t1_len", 64'(packet_length), 64'(4));
    chk("t1_accept_bank1", 64'(usb_accept), 64'(1));
    cpu_read_request = 1'b1; cpu_read_index = 8'd2;
    #1;
    chk("t1_grant_en",   64'(ram_enable), 64'(1));
    chk("t1_grant_wr",   64'(ram_write), 64'(0));
    chk("t1_grant_addr", 64'(ram_address), 64'(2));
    cyc();
    chk("t1_ready", 64'(cpu_read_ready), 64'(1));
    chk("t1_rdata", 64'(cpu_read_data), 64'(32'hA2));
    #1;
    chk("t1_no_regrant", 64'(ram_enable), 64'(0));
    cpu_read_request = 1'b0;
    cyc();
    chk("t1_ready_pulse", 64'(cpu_read_ready), 64'(0));
    chk("t1_rdata_hold",  64'(cpu_read_data), 64'(32'hA2));
    release_pkt();
    chk("t1_irq_after_rel", 64'(packet_interrupt), 64'(1));
    cyc();
    chk("t1_irq_fall", 64'(packet_interrupt), 64'(0));
    chk("t1_len_bank1", 64'(packet_length), 64'(0));

    // Two packets buffered (lengths 3 then 7), third dropped
    send_start();
    for (int i = 0; i < 3; i++) send_write(8'(i), 32'(32'h30 + i), 1'b1, 9'(256 + i));
    send_end();
    send_start();
    for (int i = 0; i < 7; i++) send_write(8'(i), 32'(32'hB0 + i), 1'b1, 9'(i));
    send_end();
    cyc();
    chk("t2_accept_full", 64'(usb_accept), 64'(0));
    chk("t2_irq", 64'(packet_interrupt), 64'(1));
    chk("t2_len_first", 64'(packet_length), 64'(3));
    send_start();
    chk("t2_drop1", 64'(dropped_count), 64'(1));
    send_write(8'd0, 32'hEE, 1'b0, 9'd0);
    send_end();
    chk("t2_len_unchanged", 64'(packet_length), 64'(3));
    release_pkt();
    cyc();
    chk("t2_irq_stays", 64'(packet_interrupt), 64'(1));
    chk("t2_len_second", 64'(packet_length), 64'(7));
    chk("t2_accept_freed", 64'(usb_accept), 64'(1));

    // CPU read held off by three USB writes, granted on the fourth cycle
    send_start();
    cpu_read_request = 1'b1; cpu_read_index = 8'd4;
    for (int i = 0; i < 3; i++) begin
      usb_write = 1'b1; usb_write_index = 8'(i); usb_write_data = 32'(32'hC0 + i);
      #1;
      chk("t3_write_wins", 64'(ram_write), 64'(1));
      chk("t3_write_addr", 64'(ram_address), 64'(256 + i));
      chk("t3_no_ready",   64'(cpu_read_ready), 64'(0));
      cyc();
    end
    usb_write = 1'b0;
    #1;
    chk("t3_grant_en",   64'(ram_enable), 64'(1));
    chk("t3_grant_wr",   64'(ram_write), 64'(0));
    chk("t3_grant_addr", 64'(ram_address), 64'(4));
    chk("t3_ready_pre",  64'(cpu_read_ready), 64'(0));
    cyc();
    chk("t3_ready", 64'(cpu_read_ready), 64'(1));
    chk("t3_rdata", 64'(cpu_read_data), 64'(32'hB4));
    cpu_read_request = 1'b0;
    // End of bank 1 together with release of bank 0
    usb_end = 1'b1; cpu_release = 1'b1;
    cyc();
    usb_end = 1'b0; cpu_release = 1'b0;
    chk("t3_len_bank1", 64'(packet_length), 64'(3));
    chk("t3_accept_bank0", 64'(usb_accept), 64'(1));
    cyc();
    chk("t3_irq", 64'(packet_interrupt), 64'(1));
    release_pkt();

    // Length saturates at 256 and keeps the maximum
    send_start();
    send_write(8'd255, 32'h55, 1'b1, 9'd255);
    send_write(8'd5, 32'h05, 1'b1, 9'd5);
    send_end();
    cyc();
    chk("t4_len_256", 64'(packet_length), 64'(256));
    chk("t4_irq", 64'(packet_interrupt), 64'(1));
    release_pkt();

    // Empty packet still becomes READY with length 0
    send_start();
    send_end();
    cyc();
    chk("t5_irq", 64'(packet_interrupt), 64'(1));
    chk("t5_len0", 64'(packet_length), 64'(0));

    // Reset mid-packet with a read granted
    send_start();
    send_write(8'd0, 32'hD0, 1'b1, 9'd0);
    cpu_read_request = 1'b1; cpu_read_index = 8'd0;
    #1;
    chk("t6_grant_en",   64'(ram_enable), 64'(1));
    chk("t6_grant_addr", 64'(ram_address), 64'(256));
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ram_en",  64'(ram_enable), 64'(0));
    chk("t6_ready",   64'(cpu_read_ready), 64'(0));
    chk("t6_rdata",   64'(cpu_read_data), 64'(0));
    chk("t6_irq",     64'(packet_interrupt), 64'(0));
    chk("t6_len",     64'(packet_length), 64'(0));
    chk("t6_drop",    64'(dropped_count), 64'(0));
    chk("t6_accept",  64'(usb_accept), 64'(1));
    cyc(); cyc();
    chk("t6_ready_in_rst", 64'(cpu_read_ready), 64'(0));
    reset = 1'b0;
    cyc();
    chk("t6_no_grant", 64'(ram_enable), 64'(0));
    chk("t6_ready_after1", 64'(cpu_read_ready), 64'(0));
    cyc();
    chk("t6_ready_after2", 64'(cpu_read_ready), 64'(0));
    cpu_read_request = 1'b0;

    // Start coinciding with release of the write bank is a drop; then saturate
    send_start(); send_end();
    send_start(); send_end();
    chk("t7_accept_full", 64'(usb_accept), 64'(0));
    usb_start = 1'b1; cpu_release = 1'b1;
    cyc();
    usb_start = 1'b0; cpu_release = 1'b0;
    chk("t7_drop_on_release", 64'(dropped_count), 64'(1));
    chk("t7_accept_after_rel", 64'(usb_accept), 64'(1));
    send_start(); send_end();
    chk("t7_accept_full2", 64'(usb_accept), 64'(0));
    for (int i = 0; i < 254; i++) send_start();
    chk("t7_drop_255", 64'(dropped_count), 64'(255));
    for (int i = 0; i < 45; i++) send_start();
    chk("t7_drop_sat", 64'(dropped_count), 64'(255));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
